// File: rtl/n163_pkg.sv
// Shared Namco 163 mapper constants: CPU address pages and the sound RAM pointer type.
package n163_pkg;

    // Page numbers are CPU address bits [15:11].
    localparam logic [4:0] N163_DATA_PAGE = 5'b01001;  // $4800-$4FFF sound RAM data window
    localparam logic [4:0] N163_ADDR_PAGE = 5'b11111;  // $F800-$FFFF address/autoincrement latch

    typedef logic [6:0] n163_ptr_t;

endpackage

// File: rtl/dpram.sv
// Simple dual-port synchronous RAM with registered outputs.
// On a same-address write/read in one clk, the read port returns the old data.
module dpram #(
    parameter int unsigned widthad_a = 7,
    parameter int unsigned width_a   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [widthad_a-1:0] i_address_a,
    input  logic [width_a-1:0]   i_data_a,
    input  logic                 i_wren_a,
    output logic [width_a-1:0]   o_q_a,
    input  logic [widthad_a-1:0] i_address_b,
    input  logic [width_a-1:0]   i_data_b,
    input  logic                 i_wren_b,
    output logic [width_a-1:0]   o_q_b
);

    localparam int unsigned DEPTH = 1 << widthad_a;

    logic [width_a-1:0] r_mem [DEPTH];

    // Storage array; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_wren_a) begin
            r_mem[i_address_a] <= i_data_a;
        end
        if (i_wren_b) begin
            r_mem[i_address_b] <= i_data_b;
        end
    end

    // Registered read ports; sample the array before this clk's writes land.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_q_a <= '0;
            o_q_b <= '0;
        end else begin
            o_q_a <= r_mem[i_address_a];
            o_q_b <= r_mem[i_address_b];
        end
    end

endmodule

// File: rtl/n163_sound_ram_port.sv
// CPU read/write port for the N163 sound RAM: $F800 pointer latch, $4800 data window with
// optional autoincrement, registered CPU read-back and a 1-clk mixer read port.
module n163_sound_ram_port
    import n163_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned READ_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ce,
    input  logic [15:0]       i_prg_ain,
    input  logic              i_prg_read,
    input  logic              i_prg_write,
    input  logic [7:0]        i_prg_din,
    output logic [7:0]        o_prg_dout,
    output logic              o_prg_oe,
    input  logic [ADDR_W-1:0] i_mix_addr,
    output logic [7:0]        o_mix_data,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_autoinc
);

    logic [ADDR_W-1:0] r_ptr;
    logic              r_autoinc;
    logic [7:0]        r_prg_dout;

    logic       w_data_sel;
    logic       w_addr_sel;
    logic       w_latch_wr;
    logic       w_ram_wr;
    logic       w_inc;
    logic [7:0] w_q_a;
    logic       w_unused_ain;

    // Address decode and per-ce bus operations.
    always_comb begin
        w_data_sel   = (i_prg_ain[15:11] == N163_DATA_PAGE);
        w_addr_sel   = (i_prg_ain[15:11] == N163_ADDR_PAGE);
        w_latch_wr   = i_ce & i_prg_write & w_addr_sel;
        // A write coincident with reset is dropped.
        w_ram_wr     = i_ce & i_prg_write & w_data_sel & ~i_reset;
        w_inc        = i_ce & (i_prg_read | i_prg_write) & w_data_sel & r_autoinc;
        w_unused_ain = ^i_prg_ain[10:0];
    end

    // Pointer/autoincrement latch; a latch write wins over an increment.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr     <= '0;
            r_autoinc <= 1'b0;
        end else if (w_latch_wr) begin
            r_ptr     <= i_prg_din[ADDR_W-1:0];
            r_autoinc <= i_prg_din[7];
        end else if (w_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // CPU read data follows RAM[ptr] between accesses and holds across the ce clk.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prg_dout <= 8'h00;
        end else if (!i_ce) begin
            r_prg_dout <= w_q_a;
        end
    end

    dpram #(
        .widthad_a(ADDR_W),
        .width_a  (8)
    ) u_ram (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_address_a(r_ptr),
        .i_data_a   (i_prg_din),
        .i_wren_a   (w_ram_wr),
        .o_q_a      (w_q_a),
        .i_address_b(i_mix_addr),
        .i_data_b   (8'h00),
        .i_wren_b   (1'b0),
        .o_q_b      (o_mix_data)
    );

    assign o_prg_oe   = (READ_EN != 0) & i_prg_read & w_data_sel;
    assign o_prg_dout = r_prg_dout;
    assign o_ptr      = r_ptr;
    assign o_autoinc  = r_autoinc;

endmodule

// File: tb/tb_n163_sound_ram_port.sv
// Bench for n163_sound_ram_port: directed scenarios plus randomized CPU traffic checked against
// an array-based model of the sound RAM, pointer and autoincrement flag.
module tb_n163_sound_ram_port;
    import n163_pkg::*;

    localparam int RAM_SIZE = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [15:0] prg_ain;
    logic        prg_read;
    logic        prg_write;
    logic [7:0]  prg_din;
    logic [7:0]  prg_dout;
    logic        prg_oe;
    logic [6:0]  mix_addr;
    logic [7:0]  mix_data;
    logic [6:0]  ptr;
    logic        autoinc;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [7:0] m_ram   [RAM_SIZE];
    bit         m_known [RAM_SIZE];
    int         m_ptr;
    bit         m_auto;

    n163_sound_ram_port #(
        .ADDR_W (7),
        .READ_EN(1)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_ce       (ce),
        .i_prg_ain  (prg_ain),
        .i_prg_read (prg_read),
        .i_prg_write(prg_write),
        .i_prg_din  (prg_din),
        .o_prg_dout (prg_dout),
        .o_prg_oe   (prg_oe),
        .i_mix_addr (mix_addr),
        .o_mix_data (mix_data),
        .o_ptr      (ptr),
        .o_autoinc  (autoinc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_step(input logic [15:0] a, input logic rd, input logic wr,
                                       input logic [7:0] d);
        if (wr && a[15:11] == N163_ADDR_PAGE) begin
            m_auto = d[7];
            m_ptr  = int'(d[6:0]);
        end else if ((rd || wr) && a[15:11] == N163_DATA_PAGE) begin
            if (wr) begin
                m_ram[m_ptr]   = d;
                m_known[m_ptr] = 1'b1;
            end
            if (m_auto) m_ptr = (m_ptr + 1) % RAM_SIZE;
        end
    endfunction

    // One CPU bus access with a single ce strobe; returns what the CPU sees at the ce clk.
    task automatic bus(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] d,
                       output logic [7:0] dout, output logic oe);
        @(negedge clk);
        prg_ain = a; prg_read = rd; prg_write = wr; prg_din = d;
        repeat (2) @(negedge clk);
        dout = prg_dout;
        oe   = prg_oe;
        ce   = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
        prg_read = 1'b0; prg_write = 1'b0; prg_ain = 16'h0000;
        repeat (3) @(negedge clk);
        model_step(a, rd, wr, d);
    endtask

    task automatic mix_read(input logic [6:0] a, output logic [7:0] q);
        @(negedge clk);
        mix_addr = a;
        @(negedge clk);
        q = mix_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (ptr !== 7'h00) begin
            n_fail++; $display("FAIL reset_ptr: got %0h expected 0", ptr);
        end
        if (autoinc !== 1'b0) begin
            n_fail++; $display("FAIL reset_autoinc: got %0b expected 0", autoinc);
        end
        if (prg_dout !== 8'h00) begin
            n_fail++; $display("FAIL reset_dout: got %0h expected 0", prg_dout);
        end
        if (mix_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_mix_data: got %0h expected 0", mix_data);
        end
        if (prg_oe !== 1'b0) begin
            n_fail++; $display("FAIL reset_oe: got %0b expected 0", prg_oe);
        end
        reset = 1'b0;
        m_ptr = 0; m_auto = 1'b0;
    endtask

    task automatic test_autoinc_rw();
        logic [7:0] dout;
        logic       oe;
        logic [7:0] exp_vals [3];
        exp_vals[0] = 8'h11; exp_vals[1] = 8'h22; exp_vals[2] = 8'h33;
        bus(16'hF800, 1'b0, 1'b1, 8'h80, dout, oe);
        for (int i = 0; i < 3; i++) bus(16'h4800, 1'b0, 1'b1, exp_vals[i], dout, oe);
        bus(16'hF800, 1'b0, 1'b1, 8'h80, dout, oe);
        for (int i = 0; i < 3; i++) begin
            bus(16'h4800, 1'b1, 1'b0, 8'h00, dout, oe);
            n_checks += 2;
            if (dout !== exp_vals[i]) begin
                n_fail++; $display("FAIL autoinc_read%0d: got %0h expected %0h", i, dout,
                                   exp_vals[i]);
            end
            if (oe !== 1'b1) begin
                n_fail++; $display("FAIL autoinc_oe%0d: got %0b expected 1", i, oe);
            end
        end
        n_checks += 2;
        if (ptr !== 7'd3) begin
            n_fail++; $display("FAIL autoinc_ptr: got %0h expected 3", ptr);
        end
        if (autoinc !== 1'b1) begin
            n_fail++; $display("FAIL autoinc_flag: got %0b expected 1", autoinc);
        end
    endtask

    task automatic test_no_autoinc();
        logic [7:0] dout;
        logic       oe;
        bus(16'hF800, 1'b0, 1'b1, 8'h05, dout, oe);
        bus(16'h4800, 1'b0, 1'b1, 8'h5C, dout, oe);
        for (int i = 0; i < 4; i++) begin
            bus(16'h4800, 1'b1, 1'b0, 8'h00, dout, oe);
            n_checks += 2;
            if (dout !== 8'h5C) begin
                n_fail++; $display("FAIL noinc_read%0d: got %0h expected 5c", i, dout);
            end
            if (ptr !== 7'd5) begin
                n_fail++; $display("FAIL noinc_ptr%0d: got %0h expected 5", i, ptr);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] dout;
        logic       oe;
        logic [7:0] q;
        bus(16'hF800, 1'b0, 1'b1, 8'hFF, dout, oe);
        bus(16'h4800, 1'b0, 1'b1, 8'hAA, dout, oe);
        bus(16'h4800, 1'b0, 1'b1, 8'hBB, dout, oe);
        n_checks += 3;
        if (ptr !== 7'd1) begin
            n_fail++; $display("FAIL wrap_ptr: got %0h expected 1", ptr);
        end
        mix_read(7'h7F, q);
        if (q !== 8'hAA) begin
            n_fail++; $display("FAIL wrap_ram7f: got %0h expected aa", q);
        end
        mix_read(7'h00, q);
        if (q !== 8'hBB) begin
            n_fail++; $display("FAIL wrap_ram00: got %0h expected bb", q);
        end
    endtask

    task automatic test_long_hold();
        logic [7:0] dout;
        logic       oe;
        logic [7:0] pre;
        logic [7:0] post;
        bus(16'hF800, 1'b0, 1'b1, 8'h81, dout, oe);
        @(negedge clk);
        prg_ain = 16'h4800; prg_read = 1'b1;
        repeat (4) @(negedge clk);
        pre = prg_dout;
        ce  = 1'b1;
        @(negedge clk);
        post = prg_dout;
        ce   = 1'b0;
        repeat (6) @(negedge clk);
        prg_read = 1'b0; prg_ain = 16'h0000;
        repeat (3) @(negedge clk);
        model_step(16'h4800, 1'b1, 1'b0, 8'h00);
        n_checks += 4;
        if (pre !== 8'h22) begin
            n_fail++; $display("FAIL hold_pre: got %0h expected 22", pre);
        end
        if (post !== pre) begin
            n_fail++; $display("FAIL hold_stable: got %0h expected %0h", post, pre);
        end
        if (ptr !== 7'd2) begin
            n_fail++; $display("FAIL hold_ptr: got %0h expected 2", ptr);
        end
        if (prg_dout !== 8'h33) begin
            n_fail++; $display("FAIL hold_next: got %0h expected 33", prg_dout);
        end
    endtask

    task automatic test_collision();
        logic [7:0] dout;
        logic       oe;
        logic [7:0] s1;
        logic [7:0] s2;
        bus(16'hF800, 1'b0, 1'b1, 8'h40, dout, oe);
        bus(16'h4800, 1'b0, 1'b1, 8'h00, dout, oe);
        @(negedge clk);
        mix_addr = 7'h40; prg_ain = 16'h4800; prg_write = 1'b1; prg_din = 8'h5A;
        @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        s1 = mix_data;
        ce = 1'b0; prg_write = 1'b0;
        @(negedge clk);
        s2 = mix_data;
        prg_ain = 16'h0000;
        model_step(16'h4800, 1'b0, 1'b1, 8'h5A);
        n_checks += 2;
        if (s1 !== 8'h00) begin
            n_fail++; $display("FAIL collide_old: got %0h expected 00", s1);
        end
        if (s2 !== 8'h5A) begin
            n_fail++; $display("FAIL collide_new: got %0h expected 5a", s2);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] dout;
        logic       oe;
        logic [7:0] q;
        logic [15:0] oe_addr [4];
        logic        oe_rd   [4];
        logic        oe_exp  [4];
        oe_addr[0] = 16'h4000; oe_rd[0] = 1'b1; oe_exp[0] = 1'b0;
        oe_addr[1] = 16'h5000; oe_rd[1] = 1'b1; oe_exp[1] = 1'b0;
        oe_addr[2] = 16'h4800; oe_rd[2] = 1'b0; oe_exp[2] = 1'b0;
        oe_addr[3] = 16'h4FFF; oe_rd[3] = 1'b1; oe_exp[3] = 1'b1;
        bus(16'hF800, 1'b0, 1'b1, 8'h20, dout, oe);
        bus(16'h4800, 1'b0, 1'b1, 8'hC3, dout, oe);
        bus(16'hF800, 1'b0, 1'b1, 8'hA0, dout, oe);
        @(negedge clk);
        prg_ain = 16'h4800; prg_write = 1'b1; prg_din = 8'h3C;
        @(negedge clk);
        ce = 1'b1; reset = 1'b1;
        @(negedge clk);
        ce = 1'b0; reset = 1'b0; prg_write = 1'b0; prg_ain = 16'h0000;
        m_ptr = 0; m_auto = 1'b0;
        n_checks += 5;
        if (ptr !== 7'h00) begin
            n_fail++; $display("FAIL rstmid_ptr: got %0h expected 0", ptr);
        end
        if (autoinc !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_autoinc: got %0b expected 0", autoinc);
        end
        if (prg_dout !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_dout: got %0h expected 0", prg_dout);
        end
        mix_read(7'h20, q);
        if (q !== 8'hC3) begin
            n_fail++; $display("FAIL rstmid_ram: got %0h expected c3", q);
        end
        mix_read(7'h21, q);
        if (q !== m_ram[8'h21] && m_known[8'h21]) begin
            n_fail++; $display("FAIL rstmid_ram_next: got %0h expected %0h", q, m_ram[8'h21]);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            prg_ain = oe_addr[i]; prg_read = oe_rd[i]; prg_write = ~oe_rd[i];
            #1;
            n_checks++;
            if (prg_oe !== oe_exp[i]) begin
                n_fail++; $display("FAIL oe_decode %h rd=%0b: got %0b expected %0b", oe_addr[i],
                                   oe_rd[i], prg_oe, oe_exp[i]);
            end
        end
        @(negedge clk);
        prg_read = 1'b0; prg_write = 1'b0; prg_ain = 16'h0000;
    endtask

    task automatic test_random();
        logic [7:0]  dout;
        logic        oe;
        logic [7:0]  q;
        logic [15:0] a;
        logic        rd;
        logic        wr;
        logic [7:0]  d;
        logic [7:0]  exp_d;
        bit          exp_valid;
        bit          in_win;
        int          op;
        int          ma;
        bus(16'hF800, 1'b0, 1'b1, 8'h80, dout, oe);
        for (int i = 0; i < RAM_SIZE; i++) bus(16'h4800, 1'b0, 1'b1, 8'($urandom), dout, oe);
        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 9));
            d  = 8'($urandom);
            rd = 1'b0; wr = 1'b0;
            a  = 16'h4800 | 16'($urandom_range(0, 2047));
            if (op <= 1) begin
                a  = 16'hF800 | 16'($urandom_range(0, 2047));
                wr = 1'b1;
            end else if (op <= 4) begin
                wr = 1'b1;
            end else if (op <= 7) begin
                rd = 1'b1;
            end else if (op == 9) begin
                do a = 16'($urandom);
                while (a[15:11] == N163_DATA_PAGE || a[15:11] == N163_ADDR_PAGE);
                rd = 1'($urandom);
                wr = ~rd;
            end
            in_win    = (a[15:11] == N163_DATA_PAGE);
            exp_valid = m_known[m_ptr];
            exp_d     = m_ram[m_ptr];
            bus(a, rd, wr, d, dout, oe);
            n_checks += 3;
            if (oe !== (rd && in_win)) begin
                n_fail++; $display("FAIL rand_oe[%0d] a=%h: got %0b expected %0b", n, a, oe,
                                   rd && in_win);
            end
            if (ptr !== m_ptr[6:0]) begin
                n_fail++; $display("FAIL rand_ptr[%0d] a=%h: got %0h expected %0h", n, a, ptr,
                                   m_ptr[6:0]);
            end
            if (autoinc !== m_auto) begin
                n_fail++; $display("FAIL rand_autoinc[%0d]: got %0b expected %0b", n, autoinc,
                                   m_auto);
            end
            if (rd && in_win && exp_valid) begin
                n_checks++;
                if (dout !== exp_d) begin
                    n_fail++; $display("FAIL rand_read[%0d]: got %0h expected %0h", n, dout,
                                       exp_d);
                end
            end
            if (n % 8 == 0) begin
                ma = int'($urandom_range(0, RAM_SIZE - 1));
                mix_read(7'(ma), q);
                n_checks++;
                if (q !== m_ram[ma]) begin
                    n_fail++; $display("FAIL rand_mix[%0d] addr=%0h: got %0h expected %0h", n, ma,
                                       q, m_ram[ma]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; prg_ain = 16'h0000; prg_read = 1'b0; prg_write = 1'b0;
        prg_din = 8'h00; mix_addr = 7'h00;
        m_ptr = 0; m_auto = 1'b0;
        for (int i = 0; i < RAM_SIZE; i++) begin
            m_ram[i] = 8'h00; m_known[i] = 1'b0;
        end
        test_reset();
        test_autoinc_rw();
        test_no_autoinc();
        test_wrap();
        test_long_hold();
        test_collision();
        test_random();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
